resta_corrimiento: RTL and testbench

RESTA_CORRIMIENTO -- requirements
Module: resta_corrimiento

---
 rtl/resta_corrimiento.sv | 104 ++++++++++
 tb/tb_resta_corrimiento.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/resta_corrimiento.sv
// BCD (4 digits) to 14-bit binary converter using reverse double-dabble:
// shift the 30-bit {BCD,binary} register right 14 times, correcting BCD digits >= 8 by -3.
module bcd_fix (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd8) ? din - 4'd3 : din;
endmodule

module resta_corrimiento (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iCE,
  input  logic        iStart,
  input  logic [3:0]  ivUnits,
  input  logic [3:0]  ivDec,
  input  logic [3:0]  ivCent,
  input  logic [3:0]  ivMillar,
  output logic [13:0] ovBinary,
  output logic        oBusy,
  output logic        oDone,
  output logic        oError
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [29:0] r_q, r_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] bin_q, bin_d;
  logic        err_q, err_d;

  logic [29:0] r_sh;
  logic [15:0] bcd_fixed;
  logic        bcd_bad;

  assign r_sh = {1'b0, r_q[29:1]};

  // One correction per BCD field of the shifted register.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fix
    bcd_fix u_fix (
      .din  (r_sh[14+4*gi +: 4]),
      .dout (bcd_fixed[4*gi +: 4])
    );
  end

  assign bcd_bad = (ivUnits > 4'd9) | (ivDec > 4'd9) | (ivCent > 4'd9) | (ivMillar > 4'd9);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    if (iCE) begin
      case (state_q)
        IDLE: begin
          if (iStart) begin
            r_d   = {ivMillar, ivCent, ivDec, ivUnits, 14'd0};
            cnt_d = 4'd0;
            err_d = bcd_bad;
            if (bcd_bad) begin
              bin_d   = 14'd0;
              state_d = DONE;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          // Binary field takes the raw shifted bits; only BCD fields are corrected.
          r_d   = {bcd_fixed, r_sh[13:0]};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            bin_d   = r_sh[13:0];
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign ovBinary = bin_q;
  assign oBusy    = (state_q == SHIFT);
  assign oDone    = (state_q == DONE);
  assign oError   = err_q;
endmodule

// File: tb/tb_resta_corrimiento.sv
// Directed bench for resta_corrimiento: vector table, strided sweep, and stall/repulse/reset sequences.
module tb_resta_corrimiento;
  logic        iClk = 1'b0;
  logic        iReset, iCE, iStart;
  logic [3:0]  ivUnits, ivDec, ivCent, ivMillar;
  logic [13:0] ovBinary;
  logic        oBusy, oDone, oError;

  int n_checks = 0;
  int n_fail   = 0;

  resta_corrimiento dut (
    .iClk     (iClk),
    .iReset   (iReset),
    .iCE      (iCE),
    .iStart   (iStart),
    .ivUnits  (ivUnits),
    .ivDec    (ivDec),
    .ivCent   (ivCent),
    .ivMillar (ivMillar),
    .ovBinary (ovBinary),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oError   (oError)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [3:0] m, c, d, u;
    int         exp_bin;
    bit         exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Accept a start at the next posedge; return on the negedge after acceptance.
  task automatic do_start(input logic [3:0] m, c, d, u);
    @(negedge iClk);
    ivMillar = m; ivCent = c; ivDec = d; ivUnits = u;
    iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic run_conv(input logic [3:0] m, c, d, u, input int exp_bin, input bit exp_err,
                          input string tag);
    int busy, waited;
    do_start(m, c, d, u);
    busy = 0; waited = 0;
    while (!oDone && waited < 40) begin
      if (oBusy) busy++;
      @(negedge iClk);
      waited++;
    end
    check({tag, "_latency"}, waited, exp_err ? 0 : 14);
    check({tag, "_busy"}, busy, exp_err ? 0 : 14);
    check({tag, "_done"}, int'(oDone), 1);
    check({tag, "_bin"}, int'(ovBinary), exp_bin);
    check({tag, "_err"}, int'(oError), int'(exp_err));
    if (!exp_err) check({tag, "_rhi"}, int'(dut.r_q[29:14]), 0);
    @(negedge iClk);
    check({tag, "_done_1cyc"}, int'(oDone), 0);
    check({tag, "_idle"}, int'(oBusy), 0);
    check({tag, "_bin_hold"}, int'(ovBinary), exp_bin);
    check({tag, "_err_hold"}, int'(oError), int'(exp_err));
  endtask

  initial begin
    int cyc, ena_edges, waited, done_seen;
    logic [3:0] m, c, d, u;

    vecs[0]  = '{4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0};
    vecs[1]  = '{4'd0, 4'd0, 4'hA, 4'd0, 0,    1'b1};
    vecs[2]  = '{4'd1, 4'd0, 4'd2, 4'd3, 1023, 1'b0};
    vecs[3]  = '{4'd0, 4'd0, 4'd0, 4'd0, 0,    1'b0};
    vecs[4]  = '{4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0};
    vecs[5]  = '{4'd3, 4'd2, 4'd1, 4'hF, 0,    1'b1};
    vecs[6]  = '{4'd8, 4'd0, 4'd0, 4'd8, 8008, 1'b0};
    vecs[7]  = '{4'hB, 4'd0, 4'd0, 4'd0, 0,    1'b1};
    vecs[8]  = '{4'd0, 4'd0, 4'd0, 4'd1, 1,    1'b0};
    vecs[9]  = '{4'd4, 4'd0, 4'd9, 4'd6, 4096, 1'b0};
    vecs[10] = '{4'd7, 4'd6, 4'd5, 4'd4, 7654, 1'b0};
    vecs[11] = '{4'd0, 4'd8, 4'd8, 4'd8, 888,  1'b0};

    iReset = 1'b1; iCE = 1'b1; iStart = 1'b1;
    ivUnits = 4'd0; ivDec = 4'd0; ivCent = 4'd0; ivMillar = 4'd0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("rst_busy", int'(oBusy), 0);
    check("rst_done", int'(oDone), 0);
    check("rst_err", int'(oError), 0);
    check("rst_bin", int'(ovBinary), 0);
    iReset = 1'b0; iStart = 1'b0;

    foreach (vecs[i])
      run_conv(vecs[i].m, vecs[i].c, vecs[i].d, vecs[i].u, vecs[i].exp_bin, vecs[i].exp_err,
               $sformatf("vec%0d", i));

    // Strided sweep against the decimal value of the digits.
    for (int v = 0; v <= 9999; v += 97) begin
      m = 4'(v / 1000); c = 4'((v / 100) % 10); d = 4'((v / 10) % 10); u = 4'(v % 10);
      run_conv(m, c, d, u, v, 1'b0, $sformatf("sw%0d", v));
    end

    // Clock enable pulsed once every three cycles.
    @(negedge iClk);
    ivMillar = 4'd5; ivCent = 4'd0; ivDec = 4'd0; ivUnits = 4'd0;
    iStart = 1'b1; iCE = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    cyc = 0; ena_edges = 1; done_seen = 0;
    while (!done_seen && cyc < 200) begin
      cyc++;
      iCE = (cyc % 3 == 0);
      @(posedge iClk);
      if (iCE) ena_edges++;
      @(negedge iClk);
      if (oDone) done_seen = 1;
    end
    check("ce_done", done_seen, 1);
    check("ce_edges", ena_edges, 15);
    check("ce_bin", int'(ovBinary), 5000);
    iCE = 1'b0;
    repeat (2) begin
      @(posedge iClk);
      @(negedge iClk);
      check("ce_done_stall", int'(oDone), 1);
    end
    iCE = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    check("ce_done_exit", int'(oDone), 0);
    check("ce_bin_hold", int'(ovBinary), 5000);

    // New start request at shift 5 must be ignored.
    do_start(4'd2, 4'd4, 4'd6, 4'd8);
    repeat (4) @(negedge iClk);
    ivMillar = 4'd9; ivCent = 4'd1; ivDec = 4'd3; ivUnits = 4'd5;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    waited = 0;
    while (!oDone && waited < 40) begin
      @(negedge iClk);
      waited++;
    end
    check("rep_done", int'(oDone), 1);
    check("rep_bin", int'(ovBinary), 2468);
    @(negedge iClk);
    check("rep_no_restart", int'(oBusy), 0);

    // Reset at shift 7 aborts with no completion pulse.
    do_start(4'd4, 4'd3, 4'd2, 4'd1);
    repeat (6) @(negedge iClk);
    check("rst7_busy_before", int'(oBusy), 1);
    iReset = 1'b1;
    @(negedge iClk);
    check("rst7_bin", int'(ovBinary), 0);
    check("rst7_busy", int'(oBusy), 0);
    check("rst7_done", int'(oDone), 0);
    check("rst7_err", int'(oError), 0);
    iReset = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(negedge iClk);
      if (oDone) done_seen = 1;
    end
    check("rst7_no_done", done_seen, 0);
    run_conv(4'd4, 4'd3, 4'd2, 4'd1, 4321, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
